// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage multiply/divide unit with HI/LO registers.
//   Accepts mult/multu/div/divu/mthi/mtlo from E. The result is computed in the
//   issue cycle and held internally, then committed to HI/LO once the fixed busy
//   window has elapsed. The window models a multi-cycle multiplier/divider.
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-high reset
//   start, op       E-stage MDU op qualifier and code (1 mult .. 6 mtlo)
//   A, B            forwarded rs / rt operands
//   rd_sel          readout select, 0 = LO, 1 = HI
//   D_is_md         D-stage instruction is an MDU instruction
//   busy            computation in progress
//   stall_req       hold D while busy or while a long op is issuing
//   HI, LO, RD      architectural HI/LO and the mfhi/mflo readout mux
module e_mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  input  logic        D_is_md,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] RD
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       hi_nxt_q, lo_nxt_q;
  logic              wr_nxt_q;

  logic              start_long;
  logic              is_div;
  logic [63:0]       prod_s, prod_u;
  logic [31:0]       divisor;
  logic [31:0]       quo_s, rem_s, quo_u, rem_u;
  logic [31:0]       res_hi, res_lo;
  logic              res_wr;

  assign start_long = start & (op >= 3'd1) & (op <= 3'd4);
  assign is_div     = (op == 3'd3) | (op == 3'd4);

  always_comb begin
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'b0, A} * {32'b0, B};
    // Divide by 1 when B is zero (result discarded anyway) or for the signed
    // overflow case 0x80000000 / -1, whose architectural result equals A / 1.
    divisor = ((B == 32'd0) || (op == 3'd3 && A == 32'h8000_0000 && B == 32'hFFFF_FFFF))
              ? 32'd1 : B;
    quo_s   = $signed(A) / $signed(divisor);
    rem_s   = $signed(A) % $signed(divisor);
    quo_u   = A / divisor;
    rem_u   = A % divisor;
  end

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    case (op)
      3'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
      3'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
      3'd3: begin res_hi = rem_s; res_lo = quo_s; res_wr = (B != 32'd0); end
      3'd4: begin res_hi = rem_u; res_lo = quo_u; res_wr = (B != 32'd0); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_nxt_q <= 32'd0;
      lo_nxt_q <= 32'd0;
      wr_nxt_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_long) begin
            hi_nxt_q <= res_hi;
            lo_nxt_q <= res_lo;
            wr_nxt_q <= res_wr;
            cnt_q    <= is_div ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
            busy_q   <= 1'b1;
            state_q  <= StBusy;
          end else if (start && op == 3'd5) begin
            hi_q <= A;
          end else if (start && op == 3'd6) begin
            lo_q <= A;
          end
        end
        StBusy: begin
          // Any start seen here is ignored; the stall unit keeps it from happening.
          if (cnt_q == '0) begin
            if (wr_nxt_q) begin
              hi_q <= hi_nxt_q;
              lo_q <= lo_nxt_q;
            end
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign stall_req = D_is_md & (busy_q | start_long);
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign RD        = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: the driver pushes the reference result of every
// long op, and a monitor pops and compares it when busy falls.
module tb_e_mdu_ctrl;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        rd_sel;
  logic        D_is_md;
  logic        busy, stall_req;
  logic [31:0] HI, LO, RD;

  e_mdu_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .rd_sel   (rd_sel),
    .D_is_md  (D_is_md),
    .busy     (busy),
    .stall_req(stall_req),
    .HI       (HI),
    .LO       (LO),
    .RD       (RD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Reference semantics straight from the ISA rules, in 64-bit arithmetic.
  function automatic void ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint          sp, q, r;
    longint unsigned up;
    hi = m_hi;
    lo = m_lo;
    case (o)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32]; lo = sp[31:0];
      end
      3'd2: begin
        up = longint'({32'b0, a}) * longint'({32'b0, b});
        hi = up[63:32]; lo = up[31:0];
      end
      3'd3: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        hi = r[31:0]; lo = q[31:0];
      end
      3'd4: if (b != 0) begin
        hi = a % b; lo = a / b;
      end
      default: ;
    endcase
  endfunction

  // Monitor: measures each busy window and scores HI/LO as busy falls.
  int  mon_len  = 0;
  bit  mon_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      mon_len  = 0;
      mon_prev = 0;
    end else begin
      if (busy) mon_len++;
      else if (mon_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_unexpected: busy fell with no pending op, got len %0d", mon_len);
        end else begin
          e = exp_q.pop_front();
          chk("mon_hi", HI, e.hi);
          chk("mon_lo", LO, e.lo);
          chk("mon_len", 32'(mon_len), 32'(e.len));
        end
        mon_len = 0;
      end
      mon_prev = busy;
    end
  end

  always @(posedge clk) begin
    if (!reset && busy && start) begin
      n_fail++;
      $display("FAIL start_while_busy: got start=1, expected 0 while busy");
    end
  end

  // Called just after a negedge; returns just after the negedge where busy is low.
  task automatic issue_long(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic dmd, input int abort_at);
    exp_t e;
    int   len;
    bit   done;
    ref_model(o, a, b, e.hi, e.lo);
    e.len = (o <= 3'd2) ? MultN : DivN;
    exp_q.push_back(e);
    start = 1'b1; op = o; A = a; B = b; D_is_md = dmd; rd_sel = 1'($urandom_range(0, 1));
    #1;
    chk("stall_issue", 32'(stall_req), 32'(dmd));
    chk("busy_issue", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    len = 0;
    done = 0;
    for (int i = 0; i < 2 * e.len + 4 && !done; i++) begin
      #1;
      if (busy) begin
        len++;
        chk("hold_hi", HI, m_hi);
        chk("hold_lo", LO, m_lo);
        chk("stall_busy", 32'(stall_req), 32'(dmd));
        chk("rd_busy", RD, rd_sel ? m_hi : m_lo);
        if (abort_at != 0 && len == abort_at) begin
          reset = 1'b1;
          exp_q.delete();
          #1;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_hi", HI, 32'd0);
          chk("abort_lo", LO, 32'd0);
          @(negedge clk);
          #2 reset = 1'b0;
          m_hi = 32'd0;
          m_lo = 32'd0;
          return;
        end
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL busy_timeout: got busy still 1 after %0d cycles, expected 0", len);
    end
    chk("stall_after", 32'(stall_req), 32'd0);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // mthi/mtlo and no-op codes: single-edge effect, never busy, never stall.
  task automatic issue_short(input logic [2:0] o, input logic [31:0] a, input logic dmd);
    start = 1'b1; op = o; A = a; B = $urandom; D_is_md = dmd;
    #1;
    chk("short_stall", 32'(stall_req), 32'd0);
    chk("short_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd5) m_hi = a;
    if (o == 3'd6) m_lo = a;
    rd_sel = 1'b0;
    #1;
    chk("short_busy2", 32'(busy), 32'd0);
    chk("short_hi", HI, m_hi);
    chk("short_lo", LO, m_lo);
    chk("short_rd_lo", RD, m_lo);
    rd_sel = 1'b1;
    #1;
    chk("short_rd_hi", RD, m_hi);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] o;
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0; rd_sel = 1'b0; D_is_md = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_rd", RD, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the third busy cycle of a mult; nothing may land afterwards.
    issue_long(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 3);
    repeat (MultN + 3) @(negedge clk);
    #1;
    chk("abort_late_hi", HI, 32'd0);
    chk("abort_late_lo", LO, 32'd0);
    chk("abort_late_busy", 32'(busy), 32'd0);

    // Signed/unsigned multiply, with D_is_md held across the first.
    issue_long(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);
    issue_long(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    // Signed divide, then divide by zero keeps HI/LO.
    issue_long(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    issue_long(3'd4, 32'd7, 32'd0, 1'b0, 0);
    chk("divz_lo", LO, 32'hFFFF_FFFD);
    chk("divz_hi", HI, 32'hFFFF_FFFF);

    // Signed overflow case, immediately followed by a mult (back-to-back).
    issue_long(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);
    issue_long(3'd1, 32'd100, 32'hFFFF_FFFF, 1'b1, 0);
    chk("b2b_lo", LO, 32'hFFFF_FF9C);
    chk("b2b_hi", HI, 32'hFFFF_FFFF);

    // mthi/mtlo and the no-op codes.
    issue_short(3'd5, 32'h1234_5678, 1'b1);
    chk("mthi_rd", RD, 32'h1234_5678);
    issue_short(3'd6, 32'hCAFE_F00D, 1'b0);
    issue_short(3'd0, 32'hDEAD_BEEF, 1'b1);
    issue_short(3'd7, 32'hDEAD_BEEF, 1'b0);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      if (o >= 3'd1 && o <= 3'd4)
        issue_long(o, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), 0);
      else
        issue_short(o, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
